// File: rtl/exu_gpr_file_if.sv
// Shared widths and the execute-stage register-file port bundle.
// Latency: n/a (declarations only).
// Backpressure: none; the port is always ready.
package exu_gpr_pkg;
    localparam int RV_XLEN   = 32;
    localparam int RV_GPR_AW = 5;
endpackage

interface exu_gpr_if_t;
    import exu_gpr_pkg::*;

    logic [RV_GPR_AW-1:0] ra1;
    logic [RV_GPR_AW-1:0] ra2;
    logic [RV_XLEN-1:0]   rd1;
    logic [RV_XLEN-1:0]   rd2;
    logic                 wen;
    logic [RV_GPR_AW-1:0] wa;
    logic [RV_XLEN-1:0]   wd;

    modport mst (output ra1, ra2, wen, wa, wd, input rd1, rd2);
    modport slv (input ra1, ra2, wen, wa, wd, output rd1, rd2);
endinterface

// File: rtl/exu_gpr_file.sv
// Integer register file: 2 read ports, 1 write port, x0 = 0, busy scoreboard.
// Latency: reads 0 cycles (optional write bypass), writes and locks 1 cycle.
// Backpressure: none; every port is always ready and never stalls.
module exu_gpr_file
    import exu_gpr_pkg::*;
#(
    parameter bit BYPASS  = 1'b1,
    parameter int NUM_GPR = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    exu_gpr_if_t.slv             gpr_slv,
    input  logic                 lock_en,
    input  logic [RV_GPR_AW-1:0] lock_addr,
    output logic                 busy1,
    output logic                 busy2,
    output logic                 busy_wa,
    input  logic [RV_GPR_AW-1:0] dbg_ra,
    output logic [RV_XLEN-1:0]   dbg_rd
);

    logic                 wr_en;
    logic [RV_XLEN-1:0]   gpr_q [NUM_GPR];
    logic [NUM_GPR-1:1]   busy_q;
    logic [NUM_GPR-1:0]   busy_vec;
    logic [NUM_GPR-1:1]   set_mask;
    logic [NUM_GPR-1:1]   clr_mask;
    logic                 byp1;
    logic                 byp2;

    assign wr_en    = gpr_slv.wen && (gpr_slv.wa != '0);
    assign busy_vec = {busy_q, 1'b0};

    // Entry 0 is never written, so x0 reads go through the explicit zero select below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_en) begin
            gpr_q[gpr_slv.wa] <= gpr_slv.wd;
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 1; i < NUM_GPR; i++) begin
            set_mask[i] = lock_en     && (lock_addr  == RV_GPR_AW'(i));
            clr_mask[i] = gpr_slv.wen && (gpr_slv.wa == RV_GPR_AW'(i));
        end
    end

    // Set is applied after clear: a write-back and a new lock on the same
    // register retire the old producer and reserve it for the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    always_comb begin
        byp1 = BYPASS && gpr_slv.wen && (gpr_slv.wa == gpr_slv.ra1);
        byp2 = BYPASS && gpr_slv.wen && (gpr_slv.wa == gpr_slv.ra2);

        gpr_slv.rd1 = '0;
        if (gpr_slv.ra1 != '0) begin
            gpr_slv.rd1 = byp1 ? gpr_slv.wd : gpr_q[gpr_slv.ra1];
        end

        gpr_slv.rd2 = '0;
        if (gpr_slv.ra2 != '0) begin
            gpr_slv.rd2 = byp2 ? gpr_slv.wd : gpr_q[gpr_slv.ra2];
        end

        dbg_rd = '0;
        if (dbg_ra != '0) begin
            dbg_rd = gpr_q[dbg_ra];
        end

        // The issue-time WAW check must see the raw reservation, so no masking here.
        busy1   = busy_vec[gpr_slv.ra1] && !byp1;
        busy2   = busy_vec[gpr_slv.ra2] && !byp2;
        busy_wa = busy_vec[lock_addr];
    end

endmodule

// File: tb/tb_exu_gpr_file.sv
// Bench for exu_gpr_file: a bypassing and a non-bypassing instance share stimulus;
// expectations are queued at drive time and popped by a negedge monitor.
module tb_exu_gpr_file;
    import exu_gpr_pkg::*;

    localparam int M_RD1 = 1;
    localparam int M_RD2 = 2;
    localparam int M_DBG = 4;
    localparam int M_B1  = 8;
    localparam int M_B2  = 16;
    localparam int M_BWA = 32;
    localparam int M_ALL = 63;

    typedef struct {
        string       nm;
        int          mask;
        logic [31:0] rd1;
        logic [31:0] rd1n;
        logic [31:0] rd2;
        logic [31:0] rd2n;
        logic [31:0] dbg;
        logic        b1;
        logic        b1n;
        logic        b2;
        logic        b2n;
        logic        bwa;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lock_en;
    logic [4:0]  lock_addr;
    logic [4:0]  dbg_ra;
    logic        busy1_b, busy2_b, bwa_b;
    logic        busy1_n, busy2_n, bwa_n;
    logic [31:0] dbg_rd_b, dbg_rd_n;

    exp_t        sb[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    exu_gpr_if_t gi_b ();
    exu_gpr_if_t gi_n ();

    exu_gpr_file #(.BYPASS(1'b1), .NUM_GPR(32)) u_byp (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpr_slv   (gi_b),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .busy1     (busy1_b),
        .busy2     (busy2_b),
        .busy_wa   (bwa_b),
        .dbg_ra    (dbg_ra),
        .dbg_rd    (dbg_rd_b)
    );

    exu_gpr_file #(.BYPASS(1'b0), .NUM_GPR(32)) u_nb (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpr_slv   (gi_n),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .busy1     (busy1_n),
        .busy2     (busy2_n),
        .busy_wa   (bwa_n),
        .dbg_ra    (dbg_ra),
        .dbg_rd    (dbg_rd_n)
    );

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic w,
                         input logic [4:0] wa, input logic [31:0] wd, input logic le,
                         input logic [4:0] la, input logic [4:0] da);
        gi_b.ra1 = a1; gi_b.ra2 = a2; gi_b.wen = w; gi_b.wa = wa; gi_b.wd = wd;
        gi_n.ra1 = a1; gi_n.ra2 = a2; gi_n.wen = w; gi_n.wa = wa; gi_n.wd = wd;
        lock_en = le; lock_addr = la; dbg_ra = da;
    endtask

    task automatic expect_v(input string nm, input int mask,
                            input logic [31:0] rd1, input logic [31:0] rd1n,
                            input logic [31:0] rd2, input logic [31:0] rd2n,
                            input logic [31:0] dbg, input logic b1, input logic b1n,
                            input logic b2, input logic b2n, input logic bwa);
        exp_t x;
        x.nm = nm; x.mask = mask;
        x.rd1 = rd1; x.rd1n = rd1n; x.rd2 = rd2; x.rd2n = rd2n; x.dbg = dbg;
        x.b1 = b1; x.b1n = b1n; x.b2 = b2; x.b2n = b2n; x.bwa = bwa;
        sb.push_back(x);
    endtask

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if ((e.mask & M_RD1) != 0) begin
                chk(e.nm, "rd1_byp", gi_b.rd1, e.rd1);
                chk(e.nm, "rd1_nb",  gi_n.rd1, e.rd1n);
            end
            if ((e.mask & M_RD2) != 0) begin
                chk(e.nm, "rd2_byp", gi_b.rd2, e.rd2);
                chk(e.nm, "rd2_nb",  gi_n.rd2, e.rd2n);
            end
            if ((e.mask & M_DBG) != 0) begin
                chk(e.nm, "dbg_byp", dbg_rd_b, e.dbg);
                chk(e.nm, "dbg_nb",  dbg_rd_n, e.dbg);
            end
            if ((e.mask & M_B1) != 0) begin
                chk(e.nm, "busy1_byp", {31'b0, busy1_b}, {31'b0, e.b1});
                chk(e.nm, "busy1_nb",  {31'b0, busy1_n}, {31'b0, e.b1n});
            end
            if ((e.mask & M_B2) != 0) begin
                chk(e.nm, "busy2_byp", {31'b0, busy2_b}, {31'b0, e.b2});
                chk(e.nm, "busy2_nb",  {31'b0, busy2_n}, {31'b0, e.b2n});
            end
            if ((e.mask & M_BWA) != 0) begin
                chk(e.nm, "busy_wa_byp", {31'b0, bwa_b}, {31'b0, e.bwa});
                chk(e.nm, "busy_wa_nb",  {31'b0, bwa_n}, {31'b0, e.bwa});
            end
        end
    end

    initial begin
        // Reset held for three cycles, then released.
        rst_n = 1'b0;
        drive(5'd5, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
        expect_v("rst_hold", M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        expect_v("rst_rel", M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Write x7 with same-cycle read.
        drive(5'd7, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7);
        expect_v("wr7_same", M_ALL, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd7, 5'd7, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7);
        expect_v("wr7_next", M_ALL, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // x0 write and lock are discarded.
        drive(5'd0, 5'd7, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0);
        expect_v("x0_same", M_ALL, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd7, 1'b0, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        expect_v("x0_after", M_ALL, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Scoreboard: lock x3 at c0, write-back at c4.
        drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
        expect_v("lk3_c0", M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
        expect_v("lk3_c1", M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        expect_v("lk3_c3", M_B1 | M_BWA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(5'd3, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, 5'd3, 5'd3);
        expect_v("wr3_c4", M_ALL, 32'h55, 32'h0, 32'h55, 32'h0, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(5'd3, 5'd3, 1'b0, 5'd3, 32'h55, 1'b0, 5'd3, 5'd3);
        expect_v("wr3_c5", M_ALL, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Simultaneous lock and write on x9: set wins.
        drive(5'd9, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
        expect_v("lk9", M_B1 | M_BWA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd9, 5'd3, 1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, 5'd9);
        expect_v("lw9_same", M_ALL, 32'hA5, 32'h0, 32'h55, 32'h55, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(5'd9, 5'd3, 1'b0, 5'd9, 32'hA5, 1'b0, 5'd9, 5'd9);
        expect_v("lw9_next", M_ALL, 32'hA5, 32'hA5, 32'h55, 32'h55, 32'hA5,
                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // Async reset in the middle of a write to x4.
        drive(5'd4, 5'd9, 1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 5'd4);
        expect_v("wr4_pre", M_DBG | M_BWA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd4, 5'd9, 1'b0, 5'd4, 32'h11, 1'b0, 5'd0, 5'd4);
        expect_v("wr4_done", M_DBG | M_B2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11,
                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd4, 5'd9, 1'b1, 5'd4, 32'h22, 1'b1, 5'd4, 5'd4);
        #1;
        rst_n = 1'b0;
        expect_v("rst4_mid", M_DBG | M_B1 | M_B2 | M_BWA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd4, 5'd9, 1'b0, 5'd4, 32'h22, 1'b0, 5'd4, 5'd4);
        rst_n = 1'b1;
        expect_v("rst4_rel", M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd9, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        expect_v("rst_post", M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: actual=%0d pending required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
